// File: rtl/pps_pkg.sv
// Shared types and defaults for the PPS edge monitor and its helpers.
package pps_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } pps_state_e;

  localparam int unsigned NOMINAL_PERIOD_DEF = 100000000;
  localparam int unsigned TOLERANCE_DEF      = 100;
  localparam int unsigned ERR_W              = 8;

endpackage

// File: rtl/pps_sync_debounce.sv
// Synchronise an asynchronous 1-bit level, debounce it, and strobe its rising edge.
module pps_sync_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int unsigned DBC_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DBC_W-1:0]       dbc_q, dbc_d;
  logic                   filt_q, filt_d;
  logic                   filt_dly_q, filt_dly_d;
  logic                   rise_q, rise_d;
  logic                   s;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], din};
    s          = sync_q[SYNC_STAGES-1];
    filt_d     = filt_q;
    dbc_d      = '0;
    if (s != filt_q) begin
      if (dbc_q == DBC_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = s;
      end else begin
        dbc_d = dbc_q + 1'b1;
      end
    end
    filt_dly_d = filt_q;
    rise_d     = filt_q & ~filt_dly_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      dbc_q      <= '0;
      filt_q     <= 1'b0;
      filt_dly_q <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      dbc_q      <= dbc_d;
      filt_q     <= filt_d;
      filt_dly_q <= filt_dly_d;
      rise_q     <= rise_d;
    end
  end

  assign level = filt_q;
  assign rise  = rise_q;

endmodule

// File: rtl/pps_edge_monitor.sv
// PPS reference monitor: debounced edge strobe, period measurement and lock tracking.
module pps_edge_monitor
  import pps_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned NOMINAL_PERIOD  = NOMINAL_PERIOD_DEF,
  parameter int unsigned TOLERANCE       = TOLERANCE_DEF,
  parameter int unsigned LOCK_COUNT      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pps_in,
  output logic             pps_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned GOOD_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
  localparam logic [CNT_W-1:0] HI_BOUND = CNT_W'(NOMINAL_PERIOD + TOLERANCE);
  localparam logic [CNT_W-1:0] LO_BOUND =
    (NOMINAL_PERIOD > TOLERANCE) ? CNT_W'(NOMINAL_PERIOD - TOLERANCE) : '0;

  logic             level;
  logic             edge_pre;
  logic             in_tol;
  logic             timeout;
  logic [CNT_W-1:0] p_meas;
  logic [ERR_W-1:0] err_inc;

  pps_state_e       state_q, state_d;
  logic             lvl_dly_q, lvl_dly_d;
  logic [CNT_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             locked_q, locked_d;
  logic             lost_q, lost_d;

  pps_sync_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (pps_in),
    .level (level),
    .rise  (pps_pulse)
  );

  // Edge is evaluated one cycle ahead of pps_pulse so that period and
  // period_valid register alongside the strobe; pc restarts at 0 here,
  // which makes pc+1 equal to the cycles elapsed between strobes.
  always_comb begin
    edge_pre = level & ~lvl_dly_q;
    p_meas   = (pc_q == '1) ? pc_q : pc_q + 1'b1;
    in_tol   = (p_meas >= LO_BOUND) && (p_meas <= HI_BOUND);
    timeout  = !edge_pre && (p_meas > HI_BOUND);
    err_inc  = (err_q == '1) ? err_q : err_q + 1'b1;

    lvl_dly_d      = level;
    pc_d           = edge_pre ? '0 : p_meas;
    state_d        = state_q;
    good_d         = good_q;
    err_d          = err_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    locked_d       = (state_q == LOCKED);
    lost_d         = (state_q == LOST);

    unique case (state_q)
      SEARCH: begin
        if (edge_pre) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      ACQUIRE: begin
        if (edge_pre) begin
          period_d       = p_meas;
          period_valid_d = 1'b1;
          if (!in_tol) begin
            good_d = '0;
          end else if (good_q == GOOD_W'(LOCK_COUNT - 1)) begin
            state_d = LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end else if (timeout) begin
          state_d = LOST;
          good_d  = '0;
        end
      end
      LOCKED: begin
        if (edge_pre) begin
          period_d       = p_meas;
          period_valid_d = 1'b1;
          if (!in_tol) begin
            state_d = ACQUIRE;
            good_d  = '0;
            err_d   = err_inc;
          end
        end else if (timeout) begin
          state_d = LOST;
          err_d   = err_inc;
        end
      end
      LOST: begin
        if (edge_pre) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= SEARCH;
      lvl_dly_q      <= 1'b0;
      pc_q           <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      good_q         <= '0;
      err_q          <= '0;
      locked_q       <= 1'b0;
      lost_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      lvl_dly_q      <= lvl_dly_d;
      pc_q           <= pc_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      good_q         <= good_d;
      err_q          <= err_d;
      locked_q       <= locked_d;
      lost_q         <= lost_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign lost         = lost_q;
  assign err_cnt      = err_q;

endmodule
